// File: rtl/uart_dbg_bridge_if.sv
// rtl/uart_dbg_bridge_if.sv - 6800-style system bus port bundle for the UART debug bridge
interface uart_dbg_bridge_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] AD;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        rw;
  logic        vma;

  modport master (
    output bus_req, AD, DO, rw, vma,
    input  bus_gnt, DI
  );

  modport slave (
    input  bus_req, AD, DO, rw, vma,
    output bus_gnt, DI
  );
endinterface

// File: rtl/uart_dbg_bridge.sv
// rtl/uart_dbg_bridge.sv - UART command frames to one bus read/write cycle; optional DBG_TIMEOUT_EN
module uart_dbg_bridge #(
  parameter int CLK_FREQ = 4000000,
  parameter int BAUD     = 9600
) (
  input  logic              clk,
  input  logic              b_reset,
  input  logic              rxd,
  output logic              txd,
  output logic              busy,
  uart_dbg_bridge_if.master bus
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_Q = 8'h3F;

  // ---------------- serial receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_valid_q;
  logic          rx_ferr_q;

  // Synchronize rxd, find the start edge, sample mid-bit, flag good bytes and framing errors
  always_ff @(posedge clk or negedge b_reset) begin
    if (!b_reset) begin
      rx_state_q <= RX_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // a line that is high again at mid-start was only a glitch
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CNT_FULL) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CNT_FULL) begin
            rx_state_q <= RX_IDLE;
            rx_valid_q <= rx_sync_q;
            rx_ferr_q  <= !rx_sync_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- command FSM ----------------
  typedef enum logic [3:0] {
    S_CMD, S_AH, S_AL, S_WD, S_REQ, S_ACC, S_LAT, S_RESP, S_TXW
  } state_t;

  state_t      state_q;
  logic        is_rd_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  resp_q;
  logic        bus_req_q;
  logic [15:0] ad_q;
  logic [7:0]  do_q;
  logic        rw_q;
  logic        vma_q;
  logic        tx_done;
  logic        in_frame;
  logic        timed_out;

  assign in_frame = (state_q == S_AH) || (state_q == S_AL) || (state_q == S_WD);

`ifdef DBG_TIMEOUT_EN
  logic [16:0] to_q;
  logic        to_run;

  assign to_run    = in_frame || (state_q == S_REQ);
  assign timed_out = to_q[16];

  // Watchdog: restarts on every accepted byte, saturates at 65536 while a frame or grant is pending
  always_ff @(posedge clk or negedge b_reset) begin
    if (!b_reset) begin
      to_q <= '0;
    end else if (!to_run || (in_frame && rx_valid_q)) begin
      to_q <= '0;
    end else if (!to_q[16]) begin
      to_q <= to_q + 17'd1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Parse the command frame, run one bus cycle under hold, then hand the result to the transmitter
  always_ff @(posedge clk or negedge b_reset) begin
    if (!b_reset) begin
      state_q   <= S_CMD;
      is_rd_q   <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_q    <= '0;
      bus_req_q <= 1'b0;
      ad_q      <= '0;
      do_q      <= '0;
      rw_q      <= 1'b1;
      vma_q     <= 1'b0;
    end else begin
      case (state_q)
        S_CMD: begin
          if (rx_valid_q) begin
            if (rx_shift_q == CH_R || rx_shift_q == CH_W) begin
              is_rd_q <= (rx_shift_q == CH_R);
              state_q <= S_AH;
            end else begin
              resp_q  <= CH_Q;
              state_q <= S_RESP;
            end
          end
        end
        S_AH, S_AL, S_WD: begin
          if (rx_ferr_q || timed_out) begin
            state_q <= S_CMD;
          end else if (rx_valid_q) begin
            case (state_q)
              S_AH: begin
                addr_q[15:8] <= rx_shift_q;
                state_q      <= S_AL;
              end
              S_AL: begin
                addr_q[7:0] <= rx_shift_q;
                state_q     <= is_rd_q ? S_REQ : S_WD;
              end
              default: begin
                wdata_q <= rx_shift_q;
                state_q <= S_REQ;
              end
            endcase
          end
        end
        S_REQ: begin
          // grant only counts once our own request is visible to the CPU
          if (bus_req_q && bus.bus_gnt) begin
            vma_q   <= 1'b1;
            ad_q    <= addr_q;
            rw_q    <= is_rd_q;
            do_q    <= is_rd_q ? do_q : wdata_q;
            state_q <= S_ACC;
          end else if (timed_out) begin
            bus_req_q <= 1'b0;
            resp_q    <= CH_Q;
            state_q   <= S_RESP;
          end else begin
            bus_req_q <= 1'b1;
          end
        end
        S_ACC: state_q <= S_LAT;
        S_LAT: begin
          // responders answer one clock after the address, so DI is valid now
          resp_q    <= is_rd_q ? bus.DI : CH_K;
          vma_q     <= 1'b0;
          rw_q      <= 1'b1;
          bus_req_q <= 1'b0;
          state_q   <= S_RESP;
        end
        S_RESP: state_q <= S_TXW;
        S_TXW: begin
          if (tx_done) state_q <= S_CMD;
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

  // ---------------- serial transmitter ----------------
  logic          tx_active_q;
  logic [8:0]    tx_shift_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic          txd_q;

  assign tx_done = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == CNT_FULL);

  // Shift out start, eight data bits LSB first and stop; loads the response while in RESP
  always_ff @(posedge clk or negedge b_reset) begin
    if (!b_reset) begin
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      txd_q       <= 1'b1;
    end else if (!tx_active_q) begin
      txd_q <= 1'b1;
      if (state_q == S_RESP) begin
        tx_active_q <= 1'b1;
        tx_shift_q  <= {1'b1, resp_q};
        tx_cnt_q    <= '0;
        tx_bit_q    <= '0;
        txd_q       <= 1'b0;
      end
    end else if (tx_cnt_q == CNT_FULL) begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd9) begin
        tx_active_q <= 1'b0;
        txd_q       <= 1'b1;
      end else begin
        txd_q      <= tx_shift_q[0];
        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        tx_bit_q   <= tx_bit_q + 4'd1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + CW'(1);
    end
  end

  assign txd         = txd_q;
  assign busy        = (state_q != S_CMD);
  assign bus.bus_req = bus_req_q;
  assign bus.AD      = ad_q;
  assign bus.DO      = do_q;
  assign bus.rw      = rw_q;
  assign bus.vma     = vma_q;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb/tb_uart_dbg_bridge.sv - directed and randomized checks of uart_dbg_bridge against a memory-map model
module tb_uart_dbg_bridge;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 62500;
  localparam int BIT_DIV  = CLK_FREQ / BAUD;

  logic clk = 1'b0;
  logic b_reset;
  logic rxd;
  logic txd;
  logic busy;

  uart_dbg_bridge_if bus_if ();

  uart_dbg_bridge #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .b_reset (b_reset),
    .rxd     (rxd),
    .txd     (txd),
    .busy    (busy),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'hF000) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // synchronous responder (ROM/RAM stand-in)
  logic [7:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    bus_if.DI = 8'h00;
  end
  always @(posedge clk) begin
    if (bus_if.vma) begin
      if (bus_if.rw) bus_if.DI <= mem[bus_if.AD];
      else mem[bus_if.AD] <= bus_if.DO;
    end
  end

  // reference model of memory contents as the host sees it
  logic [7:0] ref_mem [logic [15:0]];
  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // bus observer
  int          vma_cycles = 0;
  int          req_rises = 0;
  logic        prev_req = 1'b0;
  logic [15:0] acc_ad = '0;
  logic        acc_rw = 1'b1;
  logic [7:0]  acc_do = '0;
  always @(negedge clk) begin
    if (bus_if.vma === 1'b1) begin
      vma_cycles++;
      acc_ad = bus_if.AD;
      acc_rw = bus_if.rw;
      acc_do = bus_if.DO;
    end
    if (bus_if.bus_req === 1'b1 && !prev_req) req_rises++;
    prev_req = (bus_if.bus_req === 1'b1);
  end

  // host-side UART receiver
  logic [7:0] resp_q [$];
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (b_reset === 1'b1 && txd === 1'b0) begin
        repeat (BIT_DIV / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_DIV) @(negedge clk);
          d[i] = txd;
        end
        repeat (BIT_DIV) @(negedge clk);
        resp_q.push_back(d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_DIV) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (BIT_DIV) @(negedge clk);
    rxd = 1'b1;
    if (!stop_ok) repeat (BIT_DIV) @(negedge clk);
  endtask

  task automatic wait_resp(input string tag, output logic [7:0] b);
    int n = 0;
    while (resp_q.size() == 0 && n < 40 * BIT_DIV) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arrived"}, 32'(resp_q.size() != 0), 32'd1);
    if (resp_q.size() != 0) b = resp_q.pop_front();
    else b = 'x;
    repeat (BIT_DIV) @(negedge clk);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a);
    int v0;
    logic [7:0] r;
    v0 = vma_cycles;
    send_byte(8'h52, 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(a[7:0], 1'b1);
    wait_resp(tag, r);
    chk({tag, "_data"}, 32'(r), 32'(model_read(a)));
    chk({tag, "_vma_w"}, 32'(vma_cycles - v0), 32'd2);
    chk({tag, "_ad"}, 32'(acc_ad), 32'(a));
    chk({tag, "_rw"}, 32'(acc_rw), 32'd1);
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [7:0] wd);
    int v0;
    logic [7:0] r;
    v0 = vma_cycles;
    send_byte(8'h57, 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(a[7:0], 1'b1);
    send_byte(wd, 1'b1);
    ref_mem[a] = wd;
    wait_resp(tag, r);
    chk({tag, "_resp"}, 32'(r), 32'h4B);
    chk({tag, "_vma_w"}, 32'(vma_cycles - v0), 32'd2);
    chk({tag, "_ad"}, 32'(acc_ad), 32'(a));
    chk({tag, "_rw"}, 32'(acc_rw), 32'd0);
    chk({tag, "_do"}, 32'(acc_do), 32'(wd));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txd"}, 32'(txd), 32'd1);
    chk({tag, "_req"}, 32'(bus_if.bus_req), 32'd0);
    chk({tag, "_ad"}, 32'(bus_if.AD), 32'h0000);
    chk({tag, "_do"}, 32'(bus_if.DO), 32'h00);
    chk({tag, "_rw"}, 32'(bus_if.rw), 32'd1);
    chk({tag, "_vma"}, 32'(bus_if.vma), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0]  r;
    logic [7:0]  b;
    logic [15:0] a;
    int          r0;
    int          n;
    int          seen;

    b_reset = 1'b0;
    rxd = 1'b1;
    bus_if.bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    b_reset = 1'b1;
    repeat (4) @(negedge clk);

    // read of the boot ROM signature
    do_read("rd_rom", 16'hF000);

    // write then read back
    do_write("wr_10", 16'h0010, 8'h3C);
    do_read("rb_10", 16'h0010);

    // bad commands: '?' and no bus request
    r0 = req_rises;
    send_byte(8'h41, 1'b1);
    wait_resp("bad41", r);
    chk("bad41_resp", 32'(r), 32'h3F);
    chk("bad41_noreq", 32'(req_rises - r0), 32'd0);
    chk("bad41_busy", 32'(busy), 32'd0);
    do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
    send_byte(b, 1'b1);
    wait_resp("badrnd", r);
    chk("badrnd_resp", 32'(r), 32'h3F);

    // top of the address space
    do_write("wr_ffff", 16'hFFFF, 8'($urandom));
    do_read("rd_ffff", 16'hFFFF);

    // randomized mix
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 0) do_write("rnd_wr", a, 8'($urandom));
      else do_read("rnd_rd", a);
    end

    // delayed grant
    bus_if.bus_gnt = 1'b0;
    a = 16'($urandom);
    send_byte(8'h52, 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(a[7:0], 1'b1);
    n = 0;
    while (bus_if.bus_req !== 1'b1 && n < 20 * BIT_DIV) begin
      @(negedge clk);
      n++;
    end
    chk("gd_req", 32'(bus_if.bus_req), 32'd1);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus_if.vma === 1'b1) seen++;
    end
    chk("gd_novma", 32'(seen), 32'd0);
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    chk("gd_vma_next", 32'(bus_if.vma), 32'd1);
    chk("gd_ad", 32'(bus_if.AD), 32'(a));
    wait_resp("gd", r);
    chk("gd_data", 32'(r), 32'(model_read(a)));

    // framing error aborts a partial frame
    send_byte(8'h52, 1'b1);
    repeat (4) @(negedge clk);
    chk("fe_busy_mid", 32'(busy), 32'd1);
    send_byte(8'hF0, 1'b0);
    chk("fe_idle", 32'(busy), 32'd0);
    chk("fe_noresp", 32'(resp_q.size()), 32'd0);

    // short start glitch ignored
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT_DIV / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * BIT_DIV) @(negedge clk);
    chk("gl_busy", 32'(busy), 32'd0);
    chk("gl_noresp", 32'(resp_q.size()), 32'd0);
    do_read("fe_after", 16'($urandom));

    // reset during response data bits
    send_byte(8'h41, 1'b1);
    n = 0;
    while (txd !== 1'b0 && n < 20 * BIT_DIV) begin
      @(negedge clk);
      n++;
    end
    chk("mr_txstart", 32'(txd), 32'd0);
    repeat (3 * BIT_DIV) @(negedge clk);
    b_reset = 1'b0;
    #1;
    chk_reset_vals("mr");
    @(negedge clk);
    b_reset = 1'b1;
    repeat (12 * BIT_DIV) @(negedge clk);
    resp_q.delete();
    do_read("mr_after", 16'hF000);

`ifdef DBG_TIMEOUT_EN
    send_byte(8'h52, 1'b1);
    send_byte(8'hF0, 1'b1);
    n = 0;
    seen = 0;
    while (busy === 1'b1 && n < 70000) begin
      @(negedge clk);
      if (txd !== 1'b1) seen++;
      n++;
    end
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_long", 32'(n >= 65000), 32'd1);
    chk("to_txd", 32'(seen), 32'd0);
    chk("to_noresp", 32'(resp_q.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

UART-driven debug bus initiator for the p601zero system. It receives short command frames from a host over a dedicated 8N1 serial line. For each frame it requests the 6800-style system bus from the CPU, performs one read or write cycle against the same responders the CPU uses (boot ROM, boot RAM, super-IO), and returns a result byte to the host. It sits beside cpu68 on the address/data bus and drives the CPU hold request.

## Interface
Parameters:
- CLK_FREQ, 4000000, frequency of clk in Hz
- BAUD, 9600, serial bit rate; bit period BIT_DIV = CLK_FREQ / BAUD, integer-truncated (416 at defaults)

Ports:
- clk  input  1  system clock (sys_clk domain); all logic on posedge
- b_reset  input  1  reset, asynchronous, active-low
- rxd  input  1  host serial in, asynchronous; idle high
- txd  output  1  host serial out; idle high
- bus_req  output  1  bus request, wired to CPU hold
- bus_gnt  input  1  CPU has released the bus
- AD  output  16  bus address
- DO  output  8  bus write data
- DI  input  8  bus read data, from chipsel mux
- rw  output  1  1 = read, 0 = write
- vma  output  1  valid memory address; high only during this block's access
- busy  output  1  high from first command byte until the response stop bit ends

## Operation
- RX: rxd passes through a 2-flop synchronizer. A falling edge starts a frame. Sample at BIT_DIV/2; low confirms the start bit, high rejects it and returns to idle. Then 8 data bits LSB first, each sampled at BIT_DIV after the previous sample, then the stop bit. Stop = 0 is a framing error: the byte is discarded and the command FSM resets to CMD.
- Command FSM states: CMD, AH, AL, WD, REQ, ACC, LAT, RESP, TXW.
- CMD: 0x52 'R' -> AH (read). 0x57 'W' -> AH (write). Any other byte -> RESP with 0x3F '?'.
- AH latches addr[15:8] -> AL. AL latches addr[7:0]; a read goes -> REQ, a write goes -> WD. WD latches the write data -> REQ.
- REQ: bus_req=1. Hold until bus_gnt=1, then -> ACC.
- ACC, one cycle: AD=addr, vma=1, rw = 1 for read or 0 for write, DO = write data -> LAT.
- LAT, one cycle: AD, rw and vma are held. On a read, DI is captured at the end of this cycle because responders are synchronous and present data one clock after the address. The bus is then released -> RESP.
- RESP loads the TX byte: the read data, 0x4B 'K' for a write, or 0x3F for a bad command -> TXW.
- TXW waits for the end of the TX stop bit -> CMD.
- TX: 8N1, LSB first. Start bit, 8 data bits, 1 stop bit, each BIT_DIV clocks long.
- RX bytes that arrive while the FSM is in REQ..TXW are dropped. The host must wait for the response.
- busy = state != CMD.

## Timing
- Reset values: txd=1, bus_req=0, AD=0x0000, DO=0x00, rw=1, vma=0, busy=0. RX, TX and FSM go idle.
- If b_reset is asserted mid-operation, everything aborts immediately to reset values. A partial TX frame is truncated and txd is forced high.
- Bus hold latency: bus_req rises the cycle after REQ is entered. vma rises the cycle after bus_gnt is sampled high. vma is 2 cycles wide. bus_req falls the cycle after LAT.
- If bus_gnt drops during ACC/LAT, the access still completes. The grant is sampled only in REQ.
- The response start bit begins on the cycle after RESP, i.e. within 2 clocks of bus release.
- Worst case RX sampling error is half a bit. The divisor truncation error is below 0.2% at defaults.
- Address latched as 0xFFFF is valid. There is no wrap or auto-increment.

## Configuration
- DBG_TIMEOUT_EN defined: a 17-bit counter clears on each accepted RX byte and counts while in AH, AL or WD. At 65536 clocks it returns to CMD with no response. It also counts in REQ. If bus_gnt has not arrived after 65536 clocks, bus_req drops and 0x3F is sent.
- DBG_TIMEOUT_EN undefined: partial frames and REQ wait indefinitely, and no counter logic is present.

## Test plan
- Read: RX 'R',0xF0,0x00 with ROM[0xF000]=0xA5 and bus_gnt tied high -> one vma pulse of 2 cycles at AD=0xF000 with rw=1, then TX byte 0xA5.
- Write then read back: 'W',0x00,0x10,0x3C -> 2-cycle vma with rw=0, DO=0x3C, AD=0x0010, TX 0x4B. Then 'R',0x00,0x10 -> TX 0x3C.
- Bad command 0x41 -> TX 0x3F, no bus_req pulse, busy back to 0 after the stop bit.
- Grant delay: hold bus_gnt low 50 cycles after bus_req -> vma stays 0 throughout, and the access starts the cycle after grant.
- Framing error: second byte sent with stop=0 -> discarded, FSM back in CMD. A following valid 'R' frame responds correctly. A 1/4-bit start glitch is ignored.
- Reset mid-TX: assert b_reset during the response data bits -> txd=1 and all outputs at reset values immediately. With DBG_TIMEOUT_EN, 'R',0xF0 followed by silence -> busy drops after 65536 clocks with txd staying high.
